// File: rtl/ddr_rx_deser.sv
// ddr_rx_deser
//   Receive-side deserializer for the DDR input path of an iCE40UP pad.
//   Each clock with sample_en high, the pad presents a bit pair: din0 (rising
//   edge, earlier bit) and din1 (falling edge, later bit). The block hunts for
//   SYNC_WORD at either bit offset, then locks, rebuilds bytes MSB first and
//   checks that the sync byte recurs every FRAME_LEN bytes. Payload bytes go
//   out through a first-word-fall-through FIFO with a valid/ready handshake.
//
// Ports
//   clk        in   system clock, also the pad input clock
//   rst_n      in   asynchronous active-low reset
//   sample_en  in   din0/din1 carry a valid bit pair this cycle
//   din0       in   rising-edge sample (earlier bit of the pair)
//   din1       in   falling-edge sample (later bit of the pair)
//   clr_ovf    in   single-cycle clear of the overflow flag
//   m_data     out  payload byte at the FIFO head
//   m_valid    out  FIFO not empty
//   m_ready    in   consumer accepts m_data when m_valid is also high
//   locked     out  alignment state is LOCKED
//   phase      out  bit offset of the current lock (0 or 1)
//   overflow   out  sticky: a payload byte was dropped on a full FIFO
module ddr_rx_deser #(
  parameter logic [7:0] SYNC_WORD  = 8'hB8,
  parameter int         FRAME_LEN  = 8,
  parameter int         MAX_MISS   = 3,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic       din0,
  input  logic       din1,
  input  logic       clr_ovf,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       locked,
  output logic       phase,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]    IDX_LAST  = 8'(FRAME_LEN - 1);
  localparam logic [3:0]    MISS_LIM  = 4'(MAX_MISS);

  typedef enum logic {S_HUNT = 1'b0, S_LOCKED = 1'b1} state_t;

  // Alignment state
  state_t     r_state;
  logic [6:0] r_sr;         // only the low 7 history bits ever reach a candidate
  logic [1:0] r_pair_cnt;
  logic [7:0] r_frame_idx;
  logic [3:0] r_miss_cnt;
  logic       r_locked;
  logic       r_phase;

  // FIFO state
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic [8:0] w_sr_next;
  logic [7:0] w_cand0;
  logic [7:0] w_cand1;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_sync_slot;
  logic [3:0] w_miss_inc;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_wr_en;
  logic       w_drop;

  // Candidates are judged on the register value after this cycle's pair.
  assign w_sr_next   = {r_sr, din0, din1};
  assign w_cand0     = w_sr_next[7:0];
  assign w_cand1     = w_sr_next[8:1];
  assign w_byte      = r_phase ? w_cand1 : w_cand0;
  assign w_byte_done = (r_state == S_LOCKED) && sample_en && (r_pair_cnt == 2'd3);
  assign w_sync_slot = (r_frame_idx == 8'd0);
  assign w_miss_inc  = r_miss_cnt + 4'd1;

  assign w_push  = w_byte_done && !w_sync_slot;
  assign w_pop   = m_valid && m_ready;
  assign w_full  = (r_count == CNT_FULL);
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  assign m_data   = r_mem[r_rd_ptr];
  assign m_valid  = (r_count != {(AW+1){1'b0}});
  assign locked   = r_locked;
  assign phase    = r_phase;
  assign overflow = r_overflow;

  // Alignment FSM: hunt for sync, then count pairs, frame bytes and sync misses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HUNT;
      r_sr        <= 7'd0;
      r_pair_cnt  <= 2'd0;
      r_frame_idx <= 8'd0;
      r_miss_cnt  <= 4'd0;
      r_locked    <= 1'b0;
      r_phase     <= 1'b0;
    end else begin
      if (sample_en) begin
        r_sr <= w_sr_next[6:0];
      end
      case (r_state)
        S_HUNT: begin
          if (sample_en && ((w_cand0 == SYNC_WORD) || (w_cand1 == SYNC_WORD))) begin
            r_state     <= S_LOCKED;
            r_locked    <= 1'b1;
            r_phase     <= (w_cand0 != SYNC_WORD); // offset 0 wins a tie
            r_pair_cnt  <= 2'd0;
            r_frame_idx <= 8'd1;
            r_miss_cnt  <= 4'd0;
          end
        end
        S_LOCKED: begin
          if (sample_en) begin
            r_pair_cnt <= r_pair_cnt + 2'd1;
          end
          if (w_byte_done) begin
            r_frame_idx <= (r_frame_idx == IDX_LAST) ? 8'd0 : r_frame_idx + 8'd1;
            if (w_sync_slot) begin
              if (w_byte == SYNC_WORD) begin
                r_miss_cnt <= 4'd0;
              end else if (w_miss_inc == MISS_LIM) begin
                r_state    <= S_HUNT;
                r_locked   <= 1'b0;
                r_miss_cnt <= 4'd0;
              end else begin
                r_miss_cnt <= w_miss_inc;
              end
            end
          end
        end
        default: begin
          r_state  <= S_HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Output FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'd0;
      end
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {(AW+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= w_byte;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A new drop beats a simultaneous clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule
